sense_capture_ctrl: RTL and testbench

// Read-timing sequencer and data capture stage directly downstream of the column sense amplifiers.
// Per accepted read it sequences three phases: bitline precharge, wordline assertion, sense enable.
// It then registers the COLS-wide differential-amp result (preout) into an output buffer.
// The buffer is presented to the read port with a valid/ready handshake.

---
 rtl/sense_capture_ctrl.sv | 110 +++++++++++
 tb/tb_sense_capture_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sense_capture_ctrl.sv
// Read-timing sequencer for the column sense path: precharge -> wordline -> sense,
// then captures the sense-amp word into a valid/ready output buffer.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | bitlines precharged, waiting for an accepted read
// PRECH  | bitline precharge before wordline, PRE_CYCLES long
// WL     | wordline asserted, bitlines developing, WL_CYCLES long
// SENSE  | wordline + sense amps on, SETTLE_CYCLES long, capture at end
module sense_capture_ctrl #(
   parameter int COLS          = 16,
   parameter int PRE_CYCLES    = 2,
   parameter int WL_CYCLES     = 3,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rd_req,
   output logic            rd_ack,
   output logic            pre_en,
   output logic            wl_en,
   output logic            sa_en,
   input  logic [COLS-1:0] preout,
   output logic [COLS-1:0] rd_data,
   output logic            rd_valid,
   input  logic            rd_ready
);

   localparam int MAX_AB = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
   localparam int MAX_P  = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
   localparam int CW     = $clog2(MAX_P + 1);

   localparam logic [CW-1:0] PRE_LD    = CW'(PRE_CYCLES - 1);
   localparam logic [CW-1:0] WL_LD     = CW'(WL_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRECH = 2'd1;
   localparam logic [1:0] S_WL    = 2'd2;
   localparam logic [1:0] S_SENSE = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          cnt_zero;
   logic          buf_free;
   logic          capture;

   assign cnt_zero = (cnt == '0);
   assign buf_free = !rd_valid || rd_ready;
   assign rd_ack   = rd_req && (state == S_IDLE) && buf_free;
   assign capture  = (state == S_SENSE) && cnt_zero;

   // Decoded from registered state so the async reset kills wl_en/sa_en at once.
   assign pre_en = (state == S_IDLE) || (state == S_PRECH);
   assign wl_en  = (state == S_WL) || (state == S_SENSE);
   assign sa_en  = (state == S_SENSE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rd_ack) begin
                  state <= S_PRECH;
                  cnt   <= PRE_LD;
               end
            end
            S_PRECH: begin
               if (cnt_zero) begin
                  state <= S_WL;
                  cnt   <= WL_LD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_WL: begin
               if (cnt_zero) begin
                  state <= S_SENSE;
                  cnt   <= SETTLE_LD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               if (cnt_zero) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         endcase
      end
   end

   // A capture on the same edge as a drain wins: the buffer refills with the new word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if (capture) begin
         rd_valid <= 1'b1;
         rd_data  <= preout;
      end else if (rd_ready) begin
         rd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sense_capture_ctrl.sv
// Directed bench for sense_capture_ctrl: scoreboard on the read port plus
// sequencing, latency, backpressure and reset checks on default and minimal timing.
module tb_sense_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_req, rd_ack, pre_en, wl_en, sa_en, rd_valid, rd_ready;
   logic [15:0] preout, rd_data;

   logic        f_rst_n;
   logic        f_rd_req, f_rd_ack, f_pre_en, f_wl_en, f_sa_en, f_rd_valid, f_rd_ready;
   logic [15:0] f_preout, f_rd_data;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   logic [15:0] sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sense_capture_ctrl dut (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_ack(rd_ack),
      .pre_en(pre_en), .wl_en(wl_en), .sa_en(sa_en), .preout(preout),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
   );

   sense_capture_ctrl #(.COLS(16), .PRE_CYCLES(1), .WL_CYCLES(1), .SETTLE_CYCLES(1)) dut_fast (
      .clk(clk), .rst_n(f_rst_n), .rd_req(f_rd_req), .rd_ack(f_rd_ack),
      .pre_en(f_pre_en), .wl_en(f_wl_en), .sa_en(f_sa_en), .preout(f_preout),
      .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_ready(f_rd_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every word the consumer takes must match the next expected word.
   always @(negedge clk) begin
      if (rst_n && rd_valid && rd_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_word", 32'(rd_data), 32'hDEAD_0000);
         end else begin
            chk("sb_data", 32'(rd_data), 32'(sb_q.pop_front()));
         end
      end
   end

   // Enable exclusivity on both instances, every cycle.
   always @(negedge clk) begin
      chk("excl_pre_wl", 32'(pre_en && wl_en), 32'd0);
      chk("sa_implies_wl", 32'(sa_en && !wl_en), 32'd0);
      chk("fast_excl_pre_wl", 32'(f_pre_en && f_wl_en), 32'd0);
      chk("fast_sa_implies_wl", 32'(f_sa_en && !f_wl_en), 32'd0);
   end

   // Called at the negedge before the accept edge; returns at the negedge where rd_valid is seen.
   task automatic run_seq(input string tag);
      int np = 0, nw = 0, ns = 0, lat = -1;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (rd_valid) begin
            lat = j;
            break;
         end
         np += int'(pre_en);
         nw += int'(wl_en);
         ns += int'(sa_en);
      end
      chk({tag, "_latency"}, 32'(lat), 32'd6);
      chk({tag, "_pre_cycles"}, 32'(np), 32'd2);
      chk({tag, "_wl_cycles"}, 32'(nw), 32'd4);
      chk({tag, "_sa_cycles"}, 32'(ns), 32'd1);
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int last_ack, lat;
      logic [15:0] val;
      rst_n = 1'b0; rd_req = 1'b0; rd_ready = 1'b1; preout = '0;
      f_rst_n = 1'b0; f_rd_req = 1'b0; f_rd_ready = 1'b1; f_preout = '0;

      // Reset state
      @(negedge clk);
      chk("rst_pre_en", 32'(pre_en), 32'd1);
      chk("rst_wl_en", 32'(wl_en), 32'd0);
      chk("rst_sa_en", 32'(sa_en), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'h0000);
      chk("rst_rd_ack", 32'(rd_ack), 32'd0);
      drive_edge();
      rst_n = 1'b1; f_rst_n = 1'b1;

      // Single read
      drive_edge();
      preout = 16'hA5C3; rd_req = 1'b1;
      @(negedge clk);
      chk("single_ack", 32'(rd_ack), 32'd1);
      sb_q.push_back(16'hA5C3);
      fork
         begin drive_edge(); rd_req = 1'b0; end
         run_seq("single");
      join

      // Backpressure
      drive_edge();
      rd_ready = 1'b0; preout = 16'h1234; rd_req = 1'b1;
      @(negedge clk);
      chk("bp_first_ack", 32'(rd_ack), 32'd1);
      sb_q.push_back(16'h1234);
      fork
         begin drive_edge(); rd_req = 1'b0; end
         run_seq("bp_first");
      join
      drive_edge();
      rd_req = 1'b1; preout = 16'h5678;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_hold_ack", 32'(rd_ack), 32'd0);
         chk("bp_hold_data", 32'(rd_data), 32'h1234);
         chk("bp_hold_valid", 32'(rd_valid), 32'd1);
         if (k < 9) drive_edge();
      end
      drive_edge();
      rd_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ack", 32'(rd_ack), 32'd1);
      sb_q.push_back(16'h5678);
      fork
         begin drive_edge(); rd_req = 1'b0; end
         run_seq("bp_second");
      join

      // Back-to-back with rd_req held high
      drive_edge();
      rd_req = 1'b1;
      last_ack = 0;
      for (int i = 0; i < 4; i++) begin
         lat = -1;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rd_ack) begin
               lat = k;
               break;
            end
         end
         if (lat < 0) begin
            chk("b2b_ack_timeout", 32'd0, 32'd1);
            break;
         end
         if (i > 0) chk("b2b_spacing", 32'(cyc - last_ack), 32'd7);
         last_ack = cyc;
         val = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
         sb_q.push_back(val);
         drive_edge();
         preout = val;
         if (i == 3) rd_req = 1'b0;
      end
      repeat (10) @(negedge clk);
      chk("b2b_queue_drained", 32'(sb_q.size()), 32'd0);

      // Reset during WL
      drive_edge();
      preout = 16'hBEEF; rd_req = 1'b1;
      @(negedge clk);
      chk("mid_ack", 32'(rd_ack), 32'd1);
      drive_edge();
      rd_req = 1'b0;
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (wl_en) begin
            lat = k;
            break;
         end
      end
      chk("mid_reached_wl", 32'(lat >= 0), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wl_en", 32'(wl_en), 32'd0);
      chk("mid_rst_sa_en", 32'(sa_en), 32'd0);
      chk("mid_rst_pre_en", 32'(pre_en), 32'd1);
      chk("mid_rst_valid", 32'(rd_valid), 32'd0);
      chk("mid_rst_data", 32'(rd_data), 32'h0000);
      drive_edge();
      rst_n = 1'b1;
      drive_edge();
      preout = 16'hC0DE; rd_req = 1'b1;
      @(negedge clk);
      chk("post_rst_ack", 32'(rd_ack), 32'd1);
      sb_q.push_back(16'hC0DE);
      fork
         begin drive_edge(); rd_req = 1'b0; end
         run_seq("post_rst");
      join
      repeat (3) @(negedge clk);
      chk("final_queue_drained", 32'(sb_q.size()), 32'd0);

      // Minimal timing instance
      drive_edge();
      f_preout = 16'h3C3C; f_rd_req = 1'b1;
      @(negedge clk);
      chk("fast_ack", 32'(f_rd_ack), 32'd1);
      drive_edge();
      f_rd_req = 1'b0;
      f_preout = 16'h3C3C;
      lat = -1;
      for (int j = 0; j < 10; j++) begin
         if (j > 0) @(negedge clk);
         else @(negedge clk);
         if (f_rd_valid) begin
            lat = j;
            break;
         end
      end
      chk("fast_latency", 32'(lat), 32'd3);
      chk("fast_data", 32'(f_rd_data), 32'h3C3C);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, t=%0t expected < 200000", $time);
      $fatal(1, "watchdog");
   end

endmodule
